// File: rtl/led_page_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_page_scheduler_pkg
// Brief   : Mode/state encodings, page tag and page-advance helper shared by
//           the LED debug page scheduler.
// Revision: 1.0
// ============================================================================
package led_page_scheduler_pkg;

  localparam logic [1:0] LedModeManual = 2'b00;
  localparam logic [1:0] LedModeScan   = 2'b01;
  localparam logic [1:0] LedModeStep   = 2'b10;
  localparam logic [1:0] LedModeTrig   = 2'b11;

  localparam logic [2:0] LedStManual = 3'd0;
  localparam logic [2:0] LedStScan   = 3'd1;
  localparam logic [2:0] LedStStep   = 3'd2;
  localparam logic [2:0] LedStArmed  = 3'd3;
  localparam logic [2:0] LedStFrozen = 3'd4;

  localparam logic [7:0] LedPageTag = 8'hA5;

  // ARMED and FROZEN both belong to the trigger mode.
  function automatic logic [1:0] state_mode(input logic [2:0] st);
    logic [1:0] m;
    m = LedModeManual;
    case (st)
      LedStScan:   m = LedModeScan;
      LedStStep:   m = LedModeStep;
      LedStArmed:  m = LedModeTrig;
      LedStFrozen: m = LedModeTrig;
      default:     m = LedModeManual;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] next_page(input logic [7:0] cur,
                                           input logic [7:0] first,
                                           input logic [7:0] last);
    return (cur == last) ? first : cur + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_page_scheduler_btn_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : btn_edge_sync
// Brief   : 2-FF synchronizer plus registered rising-edge detect; emits a
//           1-cycle pulse 3 cycles after the asynchronous input rises.
// Revision: 1.0
// ============================================================================
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_pulse;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pulse <= r_sync2 & ~r_sync3;
    end
  end

  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/led_page_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : led_page_scheduler
// Brief   : Sequences the LED debug-page select (manual / auto-scan / step /
//           PC-breakpoint freeze) and registers the mux output onto the LEDs.
//           Optional page tag overlay enabled by `define LED_PAGE_TAG_EN.
// Revision: 1.0
// ============================================================================
module led_page_scheduler
  import led_page_scheduler_pkg::*;
#(
  parameter int          DWELL_CYCLES = 25_000_000,
  parameter int          CNT_W        = 25,
  parameter logic [7:0]  PAGE_FIRST   = 8'h00,
  parameter logic [7:0]  PAGE_LAST    = 8'h3F,
  parameter int          TAG_CYCLES   = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic        step_btn,
  input  logic [15:0] pc_in,
  input  logic        pc_valid,
  input  logic [15:0] bp_addr,
  input  logic [15:0] led_in,
  output logic [7:0]  page_sel,
  output logic [15:0] led_out,
  output logic        scan_active,
  output logic        frozen
);

  generate
    if (TAG_CYCLES >= DWELL_CYCLES) begin : g_bad_tag
      $error("TAG_CYCLES must be smaller than DWELL_CYCLES");
    end
    if ((DWELL_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_cnt
      $error("CNT_W too narrow for DWELL_CYCLES-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_page;
  logic [15:0]      r_led;
  logic [15:0]      w_led_src;
  logic             w_step;
  logic             w_trig;
  logic             w_mode_chg;
  logic             w_dwell_end;
  logic             w_unused_sw;

  btn_edge_sync u_step_sync (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (step_btn),
    .o_pulse (w_step)
  );

  assign w_mode_chg  = (sw[1:0] != state_mode(r_state));
  assign w_trig      = pc_valid && (pc_in == bp_addr);
  assign w_dwell_end = (r_cnt == c_DWELL_LAST);
  assign w_unused_sw = ^sw[7:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= LedStManual;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A mode switch wins over every other event in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_chg) begin
      case (sw[1:0])
        LedModeScan: w_state_nxt = LedStScan;
        LedModeStep: w_state_nxt = LedStStep;
        LedModeTrig: w_state_nxt = LedStArmed;
        default:     w_state_nxt = LedStManual;
      endcase
    end else begin
      case (r_state)
        LedStArmed:  if (w_trig) w_state_nxt = LedStFrozen;
        LedStFrozen: if (w_step) w_state_nxt = LedStArmed;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    scan_active = (r_state == LedStScan) || (r_state == LedStStep);
    frozen      = (r_state == LedStFrozen);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_page <= 8'h00;
    end else if (w_mode_chg) begin
      r_cnt  <= '0;
      r_page <= ((sw[1:0] == LedModeScan) || (sw[1:0] == LedModeStep)) ? PAGE_FIRST : sw[15:8];
    end else begin
      case (r_state)
        LedStManual, LedStArmed: r_page <= sw[15:8];
        LedStScan: begin
          if (w_dwell_end) begin
            r_cnt  <= '0;
            r_page <= next_page(r_page, PAGE_FIRST, PAGE_LAST);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LedStStep: if (w_step) r_page <= next_page(r_page, PAGE_FIRST, PAGE_LAST);
        default: r_page <= r_page;
      endcase
    end
  end

`ifdef LED_PAGE_TAG_EN
  localparam logic [CNT_W-1:0] c_TAG_LEN = CNT_W'(TAG_CYCLES);

  logic [CNT_W-1:0] r_tag_cnt;
  logic             w_tag_on;

  // Step mode has no dwell count, so a separate countdown times its tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tag_cnt <= '0;
    end else if ((w_mode_chg && (sw[1:0] == LedModeStep)) ||
                 (!w_mode_chg && (r_state == LedStStep) && w_step)) begin
      r_tag_cnt <= c_TAG_LEN;
    end else if (r_tag_cnt != '0) begin
      r_tag_cnt <= r_tag_cnt - 1'b1;
    end
  end

  assign w_tag_on  = ((r_state == LedStScan) && (r_cnt < c_TAG_LEN)) ||
                     ((r_state == LedStStep) && (r_tag_cnt != '0));
  assign w_led_src = w_tag_on ? {LedPageTag, r_page} : led_in;
`else
  assign w_led_src = led_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_led <= 16'h0000;
    end else if (r_state != LedStFrozen) begin
      r_led <= w_led_src;
    end
  end

  assign page_sel = r_page;
  assign led_out  = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_page_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_page_scheduler
// Brief   : Directed self-checking bench with an expected-value queue.
// Revision: 1.0
// ============================================================================
module tb_led_page_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic        step_btn;
  logic [15:0] pc_in;
  logic        pc_valid;
  logic [15:0] bp_addr;
  logic [15:0] led_in;
  logic [7:0]  page_sel;
  logic [15:0] led_out;
  logic        scan_active;
  logic        frozen;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] q_exp[$];
  string       q_tag[$];

  led_page_scheduler #(
    .DWELL_CYCLES (4),
    .CNT_W        (25),
    .PAGE_FIRST   (8'h3D),
    .PAGE_LAST    (8'h3F),
    .TAG_CYCLES   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .step_btn    (step_btn),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .bp_addr     (bp_addr),
    .led_in      (led_in),
    .page_sel    (page_sel),
    .led_out     (led_out),
    .scan_active (scan_active),
    .frozen      (frozen)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [15:0] v);
    q_tag.push_back(tag);
    q_exp.push_back(v);
  endtask

  task automatic check(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    n_vec++;
    if (q_exp.size() == 0) begin
      n_miss++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      assert (obs === e) else begin
        n_miss++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic pulse_step();
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick(6);
  endtask

  initial begin
    rst = 1'b0; sw = 16'hFFFF; step_btn = 1'b0;
    pc_in = 16'h0000; pc_valid = 1'b0; bp_addr = 16'h0042; led_in = 16'h5A5A;

    // reset
    expect_v("rst_page", 16'h0000); expect_v("rst_led", 16'h0000);
    expect_v("rst_frozen", 16'h0000); expect_v("rst_scan", 16'h0000);
    tick(3);
    check({8'h00, page_sel}); check(led_out);
    check({15'h0, frozen}); check({15'h0, scan_active});

    // manual
    sw = 16'h2000; rst = 1'b1;
    expect_v("man_page", 16'h0020);
    tick();
    check({8'h00, page_sel});
    led_in = 16'h1234;
    expect_v("man_led", 16'h1234);
    tick();
    check(led_out);

    // scan with wrap
    sw = 16'h0001;
    expect_v("scan_active", 16'h0001); expect_v("scan_p0", 16'h003D);
    tick();
    check({15'h0, scan_active}); check({8'h00, page_sel});
    expect_v("scan_p0_hold", 16'h003D);
    tick(3);
    check({8'h00, page_sel});
    expect_v("scan_p1", 16'h003E);
    tick();
    check({8'h00, page_sel});
    expect_v("scan_p2", 16'h003F);
    tick(4);
    check({8'h00, page_sel});
    expect_v("scan_wrap", 16'h003D);
    tick(4);
    check({8'h00, page_sel});

    // single step
    sw = 16'h0002;
    expect_v("step_entry", 16'h003D);
    tick();
    check({8'h00, page_sel});
    expect_v("step_idle", 16'h003D);
    tick(6);
    check({8'h00, page_sel});
    expect_v("step_1", 16'h003E);
    pulse_step();
    check({8'h00, page_sel});
    expect_v("step_2", 16'h003F);
    pulse_step();
    check({8'h00, page_sel});
    expect_v("step_wrap", 16'h003D);
    pulse_step();
    check({8'h00, page_sel});

    // breakpoint trigger and freeze
    sw = 16'h1403; led_in = 16'h0000;
    expect_v("armed_page", 16'h0014); expect_v("armed_frozen", 16'h0000);
    tick(2);
    check({8'h00, page_sel}); check({15'h0, frozen});
    pc_in = 16'h0042; pc_valid = 1'b1; led_in = 16'hBEEF;
    expect_v("trig_frozen", 16'h0001); expect_v("trig_led", 16'hBEEF);
    tick();
    check({15'h0, frozen}); check(led_out);
    pc_valid = 1'b0; led_in = 16'h1111; sw = 16'h5503;
    expect_v("frz_led_hold", 16'hBEEF); expect_v("frz_page_hold", 16'h0014);
    tick(2);
    check(led_out); check({8'h00, page_sel});
    pc_valid = 1'b1; led_in = 16'h2222;
    expect_v("frz_retrig_led", 16'hBEEF); expect_v("frz_retrig_frozen", 16'h0001);
    tick(2);
    check(led_out); check({15'h0, frozen});
    pc_valid = 1'b0; led_in = 16'h3333;
    expect_v("rearm_frozen", 16'h0000); expect_v("rearm_led", 16'h3333);
    expect_v("rearm_page", 16'h0055);
    pulse_step();
    check({15'h0, frozen}); check(led_out); check({8'h00, page_sel});

    // mode change beats dwell expiry
    sw = 16'h0001;
    tick();
    expect_v("prio_pre", 16'h003D);
    tick(3);
    check({8'h00, page_sel});
    sw = 16'h7700;
    expect_v("prio_page", 16'h0077); expect_v("prio_scan", 16'h0000);
    tick();
    check({8'h00, page_sel}); check({15'h0, scan_active});

    // reset while frozen discards capture
    sw = 16'h1403;
    tick(2);
    pc_in = 16'h0042; pc_valid = 1'b1; led_in = 16'hCAFE;
    expect_v("rf_led", 16'hCAFE);
    tick();
    check(led_out);
    rst = 1'b0;
    expect_v("rf_rst_led", 16'h0000); expect_v("rf_rst_frozen", 16'h0000);
    expect_v("rf_rst_page", 16'h0000);
    tick();
    check(led_out); check({15'h0, frozen}); check({8'h00, page_sel});
    rst = 1'b1; pc_valid = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
